framebuffer_replay: RTL and testbench
=====================================

FRAMEBUFFER_REPLAY -- requirements
Module: framebuffer_replay

Interface
REQ-001 SHALL have parameter NUM_FRAME, default 16, meaning frames in SDRAM ring.
REQ-002 SHALL have parameter ROWS_PER_FRAME, default 300, meaning SDRAM rows per frame.
REQ-003 SHALL have parameter COL_W, default 10, meaning column bits; columns per row = 2**COL_W.
REQ-004 SHALL have parameter ROW_W, default 15, meaning SDRAM row-address bits.
REQ-005 SHALL have parameter HOLD_CYCLES, default 2500, meaning minimum clk cycles each frame is shown.
REQ-006 SHALL have ports, in this order:
- clk  in  1  VGA-rate clock; one clock domain only.
- reset  in  1  asynchronous, active-high.
- busy  in  1  writer active; forces IDLE.
- drawBlack  in  1  clear in progress; forces IDLE.
- replay  in  1  replay enable.
- mode  in  2  00 forward, 01 reverse, 10 ping-pong, 11 step.
- step  in  1  single-cycle pulse; advances one frame in step mode.
- last_idx  in  FIDX_W  index of the last written frame; FIDX_W = max(1, clog2(NUM_FRAME)).
- raddr  out  ROW_W+COL_W  SDRAM read address {row, column}.
- frame_idx  out  FIDX_W  frame currently scanned.
- frame_start  out  1  one-cycle pulse on the first pixel of each frame scan.
- active  out  1  high while in SCAN.

Function
REQ-007 SHALL implement FSM states IDLE and SCAN.
REQ-008 SHALL treat hold = busy | drawBlack | ~replay; hold=1 in any state SHALL enter or stay in IDLE on the next edge.
REQ-009 In IDLE, SHALL load frame_idx = (last_idx+1) mod NUM_FRAME, base = frame_idx*ROWS_PER_FRAME, row=0, col=0, hold_cnt=0, dir=forward; step latch SHALL clear.
REQ-010 In IDLE with hold=0, SHALL go to SCAN next cycle; the first SCAN cycle SHALL present raddr={base,0} with frame_start=1 and active=1.
REQ-011 raddr, frame_idx, frame_start and active SHALL be registered; raddr = {base+row, col}.
REQ-012 In SCAN, col SHALL increment every cycle; at 2**COL_W-1 it SHALL wrap to 0 and row SHALL increment; at ROWS_PER_FRAME-1 row SHALL wrap to 0 (last pixel).
REQ-013 hold_cnt SHALL increment every SCAN cycle, saturate at HOLD_CYCLES, and be 0 on the first pixel of a new frame.
REQ-014 On the last pixel, advance = (mode!=11 & hold_cnt>=HOLD_CYCLES) | (mode==11 & step_latched); if advance=0, the same frame SHALL rescan with no gap and frame_start=1.
REQ-015 On advance, the next cycle SHALL be pixel 0 of the new frame; base SHALL be updated by adding or subtracting ROWS_PER_FRAME, with no multiply.
REQ-016 Forward: idx NUM_FRAME-1 SHALL wrap to 0. Reverse: idx 0 SHALL wrap to NUM_FRAME-1.
REQ-017 Ping-pong: direction SHALL reverse at idx NUM_FRAME-1 and at idx 0, so the end frame is not repeated. With NUM_FRAME=1, idx SHALL stay 0.
REQ-018 step SHALL set step_latched in any SCAN cycle. step_latched SHALL clear when consumed by an advance. step coinciding with the consuming last pixel SHALL count.
REQ-019 A mode change mid-frame SHALL take effect only at the next last pixel.
REQ-020 All arithmetic on base+row SHALL be ROW_W bits. The maximum address (NUM_FRAME*ROWS_PER_FRAME-1) SHALL fit in ROW_W; this SHALL be checked by elaboration assertion.

Reset
REQ-021 reset SHALL asynchronously force state=IDLE, frame_idx=0, base=0, row=0, col=0, hold_cnt=0, dir=forward, step_latched=0, raddr=0, frame_start=0, active=0.
REQ-022 reset or hold asserted mid-frame SHALL abandon the scan, with no completion of the current frame.

Structure
REQ-023 A shared package framebuffer_pkg SHALL hold the replay_mode_e enum (FWD, REV, PINGPONG, STEP) and the state enum.
REQ-024 The next-frame index/direction/base calculation SHALL be a sub-module frame_seq_next (combinational); scan counters and FSM stay in the top.

Verification (NUM_FRAME=4, ROWS_PER_FRAME=3, COL_W=2, HOLD_CYCLES=20, ROW_W=8)
REQ-025 Reset mid-SCAN -> raddr=0, active=0 immediately, without waiting for clk.
REQ-026 Forward: last_idx=3, replay=1 -> frame_idx=0, raddr 0x00..0x0B scanned twice; at SCAN cycle 24 -> frame_idx=1, raddr=0x0C, frame_start=1.
REQ-027 Reverse from idx 0 -> next frame idx 3, raddr=0x24. Forward from idx 3 -> idx 0, raddr=0x00.
REQ-028 Ping-pong over 8 advances -> idx sequence 0,1,2,3,2,1,0,1,2.
REQ-029 Step mode, no step pulse for 100 cycles -> idx unchanged. One pulse mid-frame -> exactly one advance, at the next frame boundary.
REQ-030 busy asserted for 1 cycle mid-frame with last_idx=1 -> IDLE; resume at idx 2, raddr=0x18, frame_start=1.

Source files
------------

// File: rtl/framebuffer_pkg.sv
// Purpose: shared types for the framebuffer replay scanner (replay mode, FSM state, scan direction).
// Latency: n/a (types and a width helper only).
// Backpressure: n/a.
package framebuffer_pkg;

    typedef enum logic [1:0] {
        FWD      = 2'b00,
        REV      = 2'b01,
        PINGPONG = 2'b10,
        STEP     = 2'b11
    } replay_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Frame-index width; a single-frame ring still needs a 1-bit index.
    function automatic int fidx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_seq_next.sv
// Purpose: computes the frame that follows the current one (index, ping-pong direction, row base).
// Latency: combinational.
// Backpressure: none; the caller decides when to take the result.
//
// Ports:
//   cur_idx/cur_base/cur_dir  frame currently being scanned and its row base / ping-pong direction
//   mode                      replay mode sampled at the frame boundary
//   nxt_idx/nxt_base/nxt_dir  the frame to scan after an advance
module frame_seq_next
    import framebuffer_pkg::*;
#(
    parameter int NUM_FRAME      = 16,
    parameter int ROWS_PER_FRAME = 300,
    parameter int ROW_W          = 15,
    parameter int FIDX_W         = 4
) (
    input  logic [FIDX_W-1:0] cur_idx,
    input  logic [ROW_W-1:0]  cur_base,
    input  dir_e              cur_dir,
    input  replay_mode_e      mode,
    output logic [FIDX_W-1:0] nxt_idx,
    output logic [ROW_W-1:0]  nxt_base,
    output dir_e              nxt_dir
);

    localparam logic [FIDX_W-1:0] LAST_IDX  = FIDX_W'(NUM_FRAME - 1);
    localparam logic [ROW_W-1:0]  STRIDE    = ROW_W'(ROWS_PER_FRAME);
    // Base of the top frame is a constant, so the wrap never needs a multiplier.
    localparam logic [ROW_W-1:0]  LAST_BASE = ROW_W'((NUM_FRAME - 1) * ROWS_PER_FRAME);

    logic go_up;

    always_comb begin
        go_up   = 1'b1;
        nxt_dir = cur_dir;
        case (mode)
            FWD, STEP: go_up = 1'b1;
            REV:       go_up = 1'b0;
            PINGPONG: begin
                // Turn around at either end so the end frame is shown only once.
                if (cur_dir == DIR_FWD) begin
                    if (cur_idx == LAST_IDX) begin
                        nxt_dir = DIR_REV;
                        go_up   = 1'b0;
                    end
                end else begin
                    go_up = 1'b0;
                    if (cur_idx == '0) begin
                        nxt_dir = DIR_FWD;
                        go_up   = 1'b1;
                    end
                end
            end
            default: go_up = 1'b1;
        endcase

        // A one-frame ring wraps onto itself in every mode, keeping idx at 0.
        if (go_up) begin
            if (cur_idx == LAST_IDX) begin
                nxt_idx  = '0;
                nxt_base = '0;
            end else begin
                nxt_idx  = cur_idx + FIDX_W'(1);
                nxt_base = cur_base + STRIDE;
            end
        end else begin
            if (cur_idx == '0) begin
                nxt_idx  = LAST_IDX;
                nxt_base = LAST_BASE;
            end else begin
                nxt_idx  = cur_idx - FIDX_W'(1);
                nxt_base = cur_base - STRIDE;
            end
        end
    end

endmodule

// File: rtl/framebuffer_replay.sv
// Purpose: replays a ring of frames stored in SDRAM by generating the pixel read address stream.
// Latency: all outputs registered; first pixel appears the cycle after IDLE sees hold drop.
// Backpressure: none; busy/drawBlack/~replay abandon the scan and park the FSM in IDLE.
//
// Ports:
//   clk, reset      single clock domain, asynchronous active-high reset
//   busy, drawBlack writer / clear activity; either one holds the scanner idle
//   replay          replay enable
//   mode            00 forward, 01 reverse, 10 ping-pong, 11 step
//   step            single-cycle pulse advancing one frame in step mode
//   last_idx        last written frame; replay starts at the frame after it
//   raddr           {row, column} read address
//   frame_idx       frame being scanned
//   frame_start     pulse on pixel 0 of every frame scan (including rescans)
//   active          high while scanning
module framebuffer_replay
    import framebuffer_pkg::*;
#(
    parameter int  NUM_FRAME      = 16,
    parameter int  ROWS_PER_FRAME = 300,
    parameter int  COL_W          = 10,
    parameter int  ROW_W          = 15,
    parameter int  HOLD_CYCLES    = 2500,
    localparam int FIDX_W         = fidx_width(NUM_FRAME)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   busy,
    input  logic                   drawBlack,
    input  logic                   replay,
    input  logic [1:0]             mode,
    input  logic                   step,
    input  logic [FIDX_W-1:0]      last_idx,
    output logic [ROW_W+COL_W-1:0] raddr,
    output logic [FIDX_W-1:0]      frame_idx,
    output logic                   frame_start,
    output logic                   active
);

    localparam int ROWC_W = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam int HC_W   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [ROWC_W-1:0] LAST_ROW = ROWC_W'(ROWS_PER_FRAME - 1);
    localparam logic [COL_W-1:0]  LAST_COL = '1;
    localparam logic [HC_W-1:0]   HOLD_MAX = HC_W'(HOLD_CYCLES);
    localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FRAME - 1);
    localparam logic [ROW_W-1:0]  STRIDE   = ROW_W'(ROWS_PER_FRAME);

    // The whole ring must be addressable with ROW_W row bits.
    if (NUM_FRAME * ROWS_PER_FRAME > (1 << ROW_W)) begin : g_row_w_check
        $error("framebuffer_replay: NUM_FRAME*ROWS_PER_FRAME does not fit in ROW_W row bits");
    end

    state_e                 state, state_d;
    dir_e                   dir, dir_d, nxt_dir;
    replay_mode_e           mode_e;
    logic [ROW_W-1:0]       base, base_d, nxt_base, idle_base, row_addr;
    logic [ROWC_W-1:0]      row, row_d;
    logic [COL_W-1:0]       col, col_d;
    logic [HC_W-1:0]        hold_cnt, hold_cnt_d;
    logic [FIDX_W-1:0]      idx_d, nxt_idx, idle_idx;
    logic                   step_latched, step_latched_d;
    logic [ROW_W+COL_W-1:0] raddr_d;
    logic                   frame_start_d, active_d;
    logic                   hold, last_pixel, advance;

    assign mode_e     = replay_mode_e'(mode);
    assign hold       = busy | drawBlack | ~replay;
    assign last_pixel = (row == LAST_ROW) && (col == LAST_COL);
    // A step arriving on the last pixel itself is honoured, not deferred a frame.
    assign advance    = (mode_e == STEP) ? (step_latched | step) : (hold_cnt >= HOLD_MAX);

    // Replay resumes at the oldest frame: the one after the last written.
    assign idle_idx   = (last_idx >= LAST_IDX) ? '0 : last_idx + FIDX_W'(1);
    assign idle_base  = STRIDE * ROW_W'(idle_idx);

    frame_seq_next #(
        .NUM_FRAME      (NUM_FRAME),
        .ROWS_PER_FRAME (ROWS_PER_FRAME),
        .ROW_W          (ROW_W),
        .FIDX_W         (FIDX_W)
    ) u_seq (
        .cur_idx  (frame_idx),
        .cur_base (base),
        .cur_dir  (dir),
        .mode     (mode_e),
        .nxt_idx  (nxt_idx),
        .nxt_base (nxt_base),
        .nxt_dir  (nxt_dir)
    );

    always_comb begin
        state_d        = state;
        idx_d          = frame_idx;
        base_d         = base;
        row_d          = row;
        col_d          = col;
        hold_cnt_d     = hold_cnt;
        dir_d          = dir;
        step_latched_d = step_latched;
        frame_start_d  = 1'b0;
        active_d       = 1'b0;

        case (state)
            ST_IDLE: begin
                idx_d          = idle_idx;
                base_d         = idle_base;
                row_d          = '0;
                col_d          = '0;
                hold_cnt_d     = '0;
                dir_d          = DIR_FWD;
                step_latched_d = 1'b0;
                if (!hold) begin
                    state_d       = ST_SCAN;
                    frame_start_d = 1'b1;
                    active_d      = 1'b1;
                end
            end
            ST_SCAN: begin
                if (hold) begin
                    // Abandon the frame; IDLE reloads everything.
                    state_d = ST_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    active_d = 1'b1;
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt_d = hold_cnt + HC_W'(1);
                    end
                    if (step) begin
                        step_latched_d = 1'b1;
                    end
                    if (!last_pixel) begin
                        if (col == LAST_COL) begin
                            col_d = '0;
                            row_d = row + ROWC_W'(1);
                        end else begin
                            col_d = col + COL_W'(1);
                        end
                    end else begin
                        // Back-to-back rescan or next frame; either way pixel 0 follows.
                        row_d         = '0;
                        col_d         = '0;
                        frame_start_d = 1'b1;
                        if (advance) begin
                            idx_d      = nxt_idx;
                            base_d     = nxt_base;
                            dir_d      = nxt_dir;
                            hold_cnt_d = '0;
                            if (mode_e == STEP) begin
                                step_latched_d = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign row_addr = base_d + ROW_W'(row_d);
    assign raddr_d  = active_d ? {row_addr, col_d} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            frame_idx    <= '0;
            base         <= '0;
            row          <= '0;
            col          <= '0;
            hold_cnt     <= '0;
            dir          <= DIR_FWD;
            step_latched <= 1'b0;
            raddr        <= '0;
            frame_start  <= 1'b0;
            active       <= 1'b0;
        end else begin
            state        <= state_d;
            frame_idx    <= idx_d;
            base         <= base_d;
            row          <= row_d;
            col          <= col_d;
            hold_cnt     <= hold_cnt_d;
            dir          <= dir_d;
            step_latched <= step_latched_d;
            raddr        <= raddr_d;
            frame_start  <= frame_start_d;
            active       <= active_d;
        end
    end

endmodule

// File: tb/tb_framebuffer_replay.sv
module tb_framebuffer_replay;

    localparam int NF   = 4;
    localparam int RPF  = 3;
    localparam int CW   = 2;
    localparam int RW   = 8;
    localparam int HOLD = 20;
    localparam int PIX  = RPF * (1 << CW);

    logic          clk = 1'b0;
    logic          reset, busy, drawBlack, replay, step;
    logic [1:0]    mode, last_idx;
    logic [RW+CW-1:0] raddr;
    logic [1:0]    frame_idx;
    logic          frame_start, active;

    int tests = 0;
    int fails = 0;

    framebuffer_replay #(
        .NUM_FRAME      (NF),
        .ROWS_PER_FRAME (RPF),
        .COL_W          (CW),
        .ROW_W          (RW),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .busy        (busy),
        .drawBlack   (drawBlack),
        .replay      (replay),
        .mode        (mode),
        .step        (step),
        .last_idx    (last_idx),
        .raddr       (raddr),
        .frame_idx   (frame_idx),
        .frame_start (frame_start),
        .active      (active)
    );

    always #5 clk = ~clk;

    // Reference model: linear pixel number within a frame, cycles the frame has been on screen,
    // and the frame index moved with plain modular arithmetic.
    bit m_scan, m_fs, m_stepl;
    int m_idx, m_pix, m_age, m_dir;

    task automatic model_reset();
        m_scan = 0; m_fs = 0; m_stepl = 0; m_idx = 0; m_pix = 0; m_age = 0; m_dir = 1;
    endtask

    task automatic model_edge();
        bit h;
        bit sl;
        bit adv;
        h = busy | drawBlack | !replay;
        if (reset) begin
            model_reset();
        end else if (!m_scan) begin
            m_fs = 0;
            if (!h) begin
                m_scan = 1; m_fs = 1; m_idx = (int'(last_idx) + 1) % NF;
                m_pix = 0; m_age = 0; m_dir = 1; m_stepl = 0;
            end
        end else if (h) begin
            m_scan = 0; m_fs = 0;
        end else begin
            sl = m_stepl | step;
            m_fs = 0;
            if (m_pix == PIX - 1) begin
                m_pix = 0; m_fs = 1;
                adv = (mode == 2'd3) ? sl : (m_age >= HOLD);
                if (adv) begin
                    case (mode)
                        2'd1: m_idx = (m_idx + NF - 1) % NF;
                        2'd2: begin
                            if (m_idx + m_dir < 0 || m_idx + m_dir >= NF) m_dir = -m_dir;
                            m_idx = m_idx + m_dir;
                        end
                        default: m_idx = (m_idx + 1) % NF;
                    endcase
                    m_age = 0;
                    if (mode == 2'd3) sl = 0;
                end else begin
                    m_age++;
                end
            end else begin
                m_pix++; m_age++;
            end
            m_stepl = sl;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_active"}, 32'(active), 32'(m_scan));
        chk({tag, "_fs"}, 32'(frame_start), 32'(m_fs));
        if (m_scan) begin
            chk({tag, "_raddr"}, 32'(raddr), 32'(m_idx * PIX + m_pix));
            chk({tag, "_idx"}, 32'(frame_idx), 32'(m_idx));
        end
    endtask

    // Park in IDLE, then enable replay; on return the DUT shows SCAN cycle 0.
    task automatic start_scan(input logic [1:0] md, input logic [1:0] li);
        replay = 0; busy = 0; drawBlack = 0; step = 0; mode = md; last_idx = li;
        tick();
        replay = 1;
        tick();
    endtask

    typedef struct {
        logic [1:0] md;
        logic [1:0] li;
        int         n;
        int         e_idx;
        int         e_addr;
        bit         e_fs;
    } vec_t;

    vec_t vecs[13];
    int   pp_seq[9];

    initial begin
        // {mode, last_idx, SCAN cycle, expected idx, raddr, frame_start}
        vecs[0]  = '{2'd0, 2'd3, 0,   0, 'h00, 1'b1};
        vecs[1]  = '{2'd0, 2'd3, 11,  0, 'h0B, 1'b0};
        vecs[2]  = '{2'd0, 2'd3, 12,  0, 'h00, 1'b1};
        vecs[3]  = '{2'd0, 2'd3, 23,  0, 'h0B, 1'b0};
        vecs[4]  = '{2'd0, 2'd3, 24,  1, 'h0C, 1'b1};
        vecs[5]  = '{2'd0, 2'd2, 24,  0, 'h00, 1'b1};
        vecs[6]  = '{2'd1, 2'd3, 24,  3, 'h24, 1'b1};
        vecs[7]  = '{2'd1, 2'd1, 24,  1, 'h0C, 1'b1};
        vecs[8]  = '{2'd0, 2'd0, 5,   1, 'h11, 1'b0};
        vecs[9]  = '{2'd3, 2'd3, 100, 0, 'h04, 1'b0};
        vecs[10] = '{2'd2, 2'd2, 24,  2, 'h18, 1'b1};
        vecs[11] = '{2'd0, 2'd3, 48,  2, 'h18, 1'b1};
        vecs[12] = '{2'd2, 2'd3, 47,  1, 'h17, 1'b0};
        pp_seq = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

        reset = 1; busy = 0; drawBlack = 0; replay = 0; step = 0; mode = 0; last_idx = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_idx", 32'(frame_idx), 0);
        reset = 0;

        for (int i = 0; i < 13; i++) begin
            start_scan(vecs[i].md, vecs[i].li);
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d_active", i), 32'(active), 1);
            chk($sformatf("vec%0d_idx", i), 32'(frame_idx), 32'(vecs[i].e_idx));
            chk($sformatf("vec%0d_raddr", i), 32'(raddr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(vecs[i].e_fs));
        end

        // Ping-pong: one advance every 24 cycles, turning at both ends.
        start_scan(2'd2, 2'd3);
        chk("pp0_idx", 32'(frame_idx), 32'(pp_seq[0]));
        for (int k = 1; k < 9; k++) begin
            repeat (24) tick();
            chk($sformatf("pp%0d_idx", k), 32'(frame_idx), 32'(pp_seq[k]));
            chk($sformatf("pp%0d_fs", k), 32'(frame_start), 1);
        end

        // Step: one mid-frame pulse gives exactly one advance at the next boundary.
        start_scan(2'd3, 2'd3);
        repeat (30) tick();
        step = 1;
        tick();
        step = 0;
        repeat (4) tick();
        chk("step_before_idx", 32'(frame_idx), 0);
        tick();
        chk("step_adv_idx", 32'(frame_idx), 1);
        chk("step_adv_raddr", 32'(raddr), 'h0C);
        chk("step_adv_fs", 32'(frame_start), 1);
        repeat (100) tick();
        chk("step_once_idx", 32'(frame_idx), 1);
        repeat (7) tick();
        // Now on the last pixel: a pulse here is consumed immediately.
        step = 1;
        tick();
        step = 0;
        chk("step_last_idx", 32'(frame_idx), 2);
        chk("step_last_fs", 32'(frame_start), 1);

        // One-cycle busy mid-frame abandons the scan and restarts after last_idx.
        start_scan(2'd0, 2'd3);
        repeat (30) tick();
        chk("busy_pre_idx", 32'(frame_idx), 1);
        last_idx = 2'd1;
        busy = 1;
        tick();
        chk("busy_active", 32'(active), 0);
        busy = 0;
        tick();
        chk("busy_resume_active", 32'(active), 1);
        chk("busy_resume_idx", 32'(frame_idx), 2);
        chk("busy_resume_raddr", 32'(raddr), 'h18);
        chk("busy_resume_fs", 32'(frame_start), 1);

        // Asynchronous reset mid-scan, observed before the next clock edge.
        start_scan(2'd0, 2'd3);
        repeat (5) tick();
        chk("arst_pre_raddr", 32'(raddr), 5);
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("arst_raddr", 32'(raddr), 0);
        chk("arst_active", 32'(active), 0);
        chk("arst_fs", 32'(frame_start), 0);
        chk("arst_idx", 32'(frame_idx), 0);
        tick();
        reset = 0;

        // Randomized traffic against the reference model.
        mode = 2'd0;
        for (int c = 0; c < 3000; c++) begin
            busy      = ($urandom_range(0, 199) == 0);
            drawBlack = ($urandom_range(0, 299) == 0);
            replay    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            step      = ($urandom_range(0, 15) == 0);
            last_idx  = 2'($urandom_range(0, 3));
            tick();
            chk_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
